// File: rtl/nv_skid_pipe_stage.sv
// Two-entry valid/ready retiming stage with a skid register.
// All outputs come from flops, so out_rdy->in_rdy and in_pd->out_pd have no combinational path.
module nv_skid_pipe_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_pd,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_pd,
  output logic [1:0]       occ
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_rst_hold;
  logic             w_accept;
  logic             w_pop;

  // r_rst_hold keeps in_rdy low through the release edge so nothing is accepted on it.
  assign in_rdy   = (r_state != ST_FULL) & ~r_rst_hold;
  assign out_vld  = (r_state != ST_EMPTY);
  assign occ      = r_state;
  assign out_pd   = r_main;
  assign w_accept = in_vld & in_rdy;
  assign w_pop    = out_vld & out_rdy;

  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      r_state    <= ST_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_rst_hold <= 1'b1;
    end else begin
      r_rst_hold <= 1'b0;
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state <= ST_ONE;
            r_main  <= in_pd;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            r_main <= in_pd;
          end else if (w_accept) begin
            r_state <= ST_FULL;
            r_skid  <= in_pd;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_state <= ST_ONE;
            r_main  <= r_skid;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_nv_skid_pipe_stage.sv
// Bench for nv_skid_pipe_stage: directed scenarios plus random traffic against a
// queue-based model of a two-deep FIFO with a one-edge post-reset accept block.
module tb_nv_skid_pipe_stage;
  localparam int W = 32;

  logic         CP = 1'b0;
  logic         CD = 1'b1;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic [W-1:0] in_pd = '0;
  logic         out_vld;
  logic         out_rdy = 1'b0;
  logic [W-1:0] out_pd;
  logic [1:0]   occ;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] sent[$];
  logic [W-1:0] got[$];
  bit           m_hold = 1'b1;
  bit           m_acc;
  bit           m_pop;

  always #5 CP = ~CP;

  nv_skid_pipe_stage #(.WIDTH(W)) dut (
    .CP(CP), .CD(CD),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_pd(in_pd),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_pd(out_pd),
    .occ(occ)
  );

  // Reference: a FIFO of depth 2 that refuses input while full or in the post-reset hold.
  always @(posedge CP or posedge CD) begin
    if (CD) begin
      mq.delete();
      m_hold = 1'b1;
    end else begin
      m_acc = (in_vld === 1'b1) && (mq.size() < 2) && !m_hold;
      m_pop = (mq.size() > 0) && (out_rdy === 1'b1);
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        mq.push_back(in_pd);
        sent.push_back(in_pd);
      end
      m_hold = 1'b0;
    end
  end

  // Record what the DUT actually delivers.
  always @(posedge CP) begin
    if (CD === 1'b0 && out_vld === 1'b1 && out_rdy === 1'b1) got.push_back(out_pd);
  end

  task automatic do_reset;
    CD = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; in_pd = '0;
    repeat (2) @(negedge CP);
    CD = 1'b0;
    repeat (2) @(negedge CP);
  endtask

  task automatic test_reset;
    @(negedge CP);
    n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_out_vld: got %b exp 0", out_vld); end
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_in_rdy: got %b exp 0", in_rdy); end
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL rst_occ: got %0d exp 0", occ); end
    n_checks++; if (out_pd !== '0) begin n_fail++; $display("FAIL rst_out_pd: got %h exp 0", out_pd); end
    // release mid-cycle while offering data: the release edge must not accept it
    CD = 1'b0; in_vld = 1'b1; in_pd = 32'h55; out_rdy = 1'b0;
    #1;
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL rel_in_rdy0: got %b exp 0", in_rdy); end
    @(negedge CP);
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL rel_no_accept: got occ %0d exp 0", occ); end
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rel_in_rdy1: got %b exp 1", in_rdy); end
    n_checks++; if (out_pd !== '0) begin n_fail++; $display("FAIL rel_out_pd: got %h exp 0", out_pd); end
    in_pd = 32'h11;
    @(negedge CP);
    in_pd = 32'h22;
    @(negedge CP);
    n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL pre_rst_full: got occ %0d exp 2", occ); end
    in_vld = 1'b0;
    #2 CD = 1'b1;
    #1;
    n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL async_out_vld: got %b exp 0", out_vld); end
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL async_in_rdy: got %b exp 0", in_rdy); end
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL async_occ: got %0d exp 0", occ); end
    n_checks++; if (out_pd !== '0) begin n_fail++; $display("FAIL async_out_pd: got %h exp 0", out_pd); end
    @(negedge CP);
    CD = 1'b0;
    #1;
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL rel2_in_rdy0: got %b exp 0", in_rdy); end
    @(negedge CP);
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rel2_in_rdy1: got %b exp 1", in_rdy); end
    n_checks++; if (out_pd !== '0) begin n_fail++; $display("FAIL rel2_out_pd: got %h exp 0", out_pd); end
  endtask

  task automatic test_streaming;
    do_reset();
    got.delete();
    out_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_vld = 1'b1; in_pd = W'(i);
      @(negedge CP);
      n_checks++; if (out_pd !== W'(i) || out_vld !== 1'b1) begin n_fail++; $display("FAIL stream_pd[%0d]: got %h/%b exp %h/1", i, out_pd, out_vld, i); end
      n_checks++; if (occ !== 2'd1 || in_rdy !== 1'b1) begin n_fail++; $display("FAIL stream_occ[%0d]: got occ %0d rdy %b exp 1/1", i, occ, in_rdy); end
    end
    in_vld = 1'b0;
    @(negedge CP);
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL stream_end_occ: got %0d exp 0", occ); end
    n_checks++; if (got.size() != 16) begin n_fail++; $display("FAIL stream_count: got %0d exp 16", got.size()); end
    else for (int i = 0; i < 16; i++) begin
      n_checks++; if (got[i] !== W'(i)) begin n_fail++; $display("FAIL stream_order[%0d]: got %h exp %h", i, got[i], i); end
    end
  endtask

  task automatic test_skid_fill;
    do_reset();
    got.delete();
    out_rdy = 1'b1; in_vld = 1'b1; in_pd = 32'hA1;
    @(negedge CP);
    n_checks++; if (occ !== 2'd1 || out_pd !== 32'hA1) begin n_fail++; $display("FAIL skid_a1: got occ %0d pd %h exp 1/a1", occ, out_pd); end
    in_pd = 32'hA2; out_rdy = 1'b0;
    @(negedge CP);
    n_checks++; if (occ !== 2'd2 || in_rdy !== 1'b0 || out_pd !== 32'hA1) begin n_fail++; $display("FAIL skid_full: got occ %0d rdy %b pd %h exp 2/0/a1", occ, in_rdy, out_pd); end
    in_pd = 32'hA3;
    for (int i = 0; i < 3; i++) begin
      @(negedge CP);
      n_checks++; if (occ !== 2'd2 || in_rdy !== 1'b0 || out_pd !== 32'hA1 || out_vld !== 1'b1) begin n_fail++; $display("FAIL skid_hold[%0d]: got occ %0d rdy %b pd %h exp 2/0/a1", i, occ, in_rdy, out_pd); end
    end
    out_rdy = 1'b1;
    @(negedge CP);
    n_checks++; if (occ !== 2'd1 || in_rdy !== 1'b1 || out_pd !== 32'hA2) begin n_fail++; $display("FAIL skid_release: got occ %0d rdy %b pd %h exp 1/1/a2", occ, in_rdy, out_pd); end
    @(negedge CP);
    n_checks++; if (occ !== 2'd1 || out_pd !== 32'hA3) begin n_fail++; $display("FAIL skid_a3: got occ %0d pd %h exp 1/a3", occ, out_pd); end
    in_vld = 1'b0;
    @(negedge CP);
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL skid_empty: got %0d exp 0", occ); end
    n_checks++; if (got.size() != 3 || got[0] !== 32'hA1 || got[1] !== 32'hA2 || got[2] !== 32'hA3) begin
      n_fail++; $display("FAIL skid_order: got %0d items exp a1,a2,a3", got.size());
    end
  endtask

  task automatic test_drain;
    do_reset();
    out_rdy = 1'b0; in_vld = 1'b1; in_pd = 32'hB1;
    @(negedge CP);
    in_pd = 32'hB2;
    @(negedge CP);
    in_vld = 1'b0;
    n_checks++; if (occ !== 2'd2 || out_pd !== 32'hB1) begin n_fail++; $display("FAIL drain_c1: got occ %0d pd %h exp 2/b1", occ, out_pd); end
    out_rdy = 1'b1;
    @(negedge CP);
    n_checks++; if (occ !== 2'd1 || out_pd !== 32'hB2) begin n_fail++; $display("FAIL drain_c2: got occ %0d pd %h exp 1/b2", occ, out_pd); end
    @(negedge CP);
    n_checks++; if (occ !== 2'd0 || out_vld !== 1'b0) begin n_fail++; $display("FAIL drain_c3: got occ %0d vld %b exp 0/0", occ, out_vld); end
  endtask

  task automatic test_illegal_upstream;
    do_reset();
    got.delete();
    out_rdy = 1'b0; in_vld = 1'b1; in_pd = 32'hC1;
    @(negedge CP);
    in_pd = 32'hC2;
    @(negedge CP);
    for (int i = 0; i < 8; i++) begin
      in_vld = (i % 2 == 0);
      in_pd  = (i % 2 == 0) ? 32'hDEAD : 32'hBEEF;
      @(negedge CP);
      n_checks++; if (occ !== 2'd2 || out_pd !== 32'hC1 || in_rdy !== 1'b0) begin n_fail++; $display("FAIL illegal_hold[%0d]: got occ %0d pd %h exp 2/c1", i, occ, out_pd); end
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    @(negedge CP);
    n_checks++; if (occ !== 2'd1 || out_pd !== 32'hC2) begin n_fail++; $display("FAIL illegal_pop1: got occ %0d pd %h exp 1/c2", occ, out_pd); end
    @(negedge CP);
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL illegal_pop2: got occ %0d exp 0", occ); end
    n_checks++; if (got.size() != 2 || got[0] !== 32'hC1 || got[1] !== 32'hC2) begin
      n_fail++; $display("FAIL illegal_order: got %0d items exp c1,c2", got.size());
    end
  endtask

  task automatic test_random;
    bit           stall = 1'b0;
    logic [W-1:0] stall_pd = '0;
    do_reset();
    got.delete();
    sent.delete();
    for (int c = 0; c < 10000; c++) begin
      n_checks++; if (occ !== 2'(mq.size())) begin n_fail++; $display("FAIL rnd_occ[%0d]: got %0d exp %0d", c, occ, mq.size()); end
      n_checks++; if (in_rdy !== ((mq.size() < 2) && !m_hold)) begin n_fail++; $display("FAIL rnd_in_rdy[%0d]: got %b", c, in_rdy); end
      n_checks++; if (out_vld !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_out_vld[%0d]: got %b", c, out_vld); end
      if (mq.size() > 0) begin
        n_checks++; if (out_pd !== mq[0]) begin n_fail++; $display("FAIL rnd_out_pd[%0d]: got %h exp %h", c, out_pd, mq[0]); end
      end
      if (stall) begin
        n_checks++; if (out_pd !== stall_pd || out_vld !== 1'b1) begin n_fail++; $display("FAIL rnd_stable[%0d]: got %h exp %h", c, out_pd, stall_pd); end
      end
      in_vld  = $urandom_range(1, 0) == 1;
      out_rdy = $urandom_range(1, 0) == 1;
      in_pd   = $urandom;
      stall    = (out_vld === 1'b1) && !out_rdy;
      stall_pd = out_pd;
      @(negedge CP);
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    repeat (3) @(negedge CP);
    n_checks++; if (got.size() != sent.size()) begin n_fail++; $display("FAIL rnd_count: got %0d exp %0d", got.size(), sent.size()); end
    else for (int i = 0; i < got.size(); i++) begin
      n_checks++; if (got[i] !== sent[i]) begin n_fail++; $display("FAIL rnd_order[%0d]: got %h exp %h", i, got[i], sent[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid_fill();
    test_drain();
    test_illegal_upstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nv_skid_pipe_stage.md
# nv_skid_pipe_stage

Single-clock, two-entry valid/ready retiming stage built from asynchronously cleared flops. It feeds the team's clear-type flop-based datapaths. It registers the payload and handshake so that no combinational path exists from `out_rdy` to `in_rdy`, or from `in_pd` to `out_pd`. Full throughput (one transfer per cycle) is sustained under back-pressure through a skid register.

## Interface
- `WIDTH`, default 32: payload width in bits (≥1).
- `CP` input 1: clock; all state updates on the rising edge.
- `CD` input 1: clear. Asynchronous, active-high. All flops clear immediately on assertion; release is synchronous to `CP` at the next edge.
- `in_vld` input 1: upstream payload valid.
- `in_rdy` output 1: stage can accept. Driven from flops only.
- `in_pd` input WIDTH: upstream payload. Don't-care when `in_vld`=0.
- `out_vld` output 1: downstream payload valid. Driven from flops.
- `out_rdy` input 1: downstream can accept.
- `out_pd` output WIDTH: downstream payload. Driven directly from the main data register.
- `occ` output 2: occupancy (0, 1 or 2). Debug/perf only.

## Operation
- Transfer rules:
  - An accept occurs on an edge where `in_vld & in_rdy`.
  - A pop occurs on an edge where `out_vld & out_rdy`.
  - No other condition moves data.
- State register has three states: EMPTY(0), ONE(1), FULL(2). Storage is `main` (drives `out_pd`) and `skid`.
- EMPTY:
  - accept → ONE, `main`←`in_pd`.
  - Otherwise stay in EMPTY.
  - `out_rdy` is ignored.
- ONE:
  - accept & pop → ONE, `main`←`in_pd`.
  - accept only → FULL, `skid`←`in_pd`.
  - pop only → EMPTY.
  - neither → hold.
- FULL:
  - `in_rdy`=0, so no accept is possible.
  - pop → ONE, `main`←`skid`.
  - Otherwise hold.
- Outputs:
  - `out_vld` = (state≠EMPTY).
  - `in_rdy` = (state≠FULL) & ~`rst_hold`.
  - `occ` = state encoding.
- `rst_hold` is a flop set by `CD` and cleared on the first `CP` edge after `CD` deasserts. `in_rdy` is therefore 0 during reset and for that first edge. No accept can occur on the release edge.
- Ordering: strictly FIFO. The `main` payload always pops before the `skid` payload.
- `out_pd` and `out_vld` are stable while `out_vld & ~out_rdy`; they are never withdrawn without a pop.
- Upstream may drop `in_vld` or change `in_pd` while `in_rdy`=0. This is legal and no transfer occurs.
- `skid` contents are don't-care unless state=FULL. `main` contents are don't-care when state=EMPTY.

## Timing
- Reset values while `CD`=1 and at release:
  - state=EMPTY, `out_vld`=0, `in_rdy`=0, `occ`=0.
  - `out_pd`=0, `skid`=0, `rst_hold`=1.
- First cycle after release: `in_rdy`=0.
- From the second edge after release: `in_rdy`=1.
- Latency: payload accepted at edge N appears on `out_pd` with `out_vld`=1 after edge N (visible in cycle N+1). One cycle, no bypass.
- Throughput: 1 transfer/cycle when `out_rdy`=1 continuously.
- Back-pressure response:
  - `out_rdy` dropping at edge N (with an accept) → FULL after N.
  - `in_rdy`=0 in cycle N+1. One extra beat is absorbed by `skid`.
- Release from FULL: a pop at edge M → `in_rdy`=1 in cycle M+1. The next accept is possible at edge M+1.
- Simultaneous accept+pop in ONE keeps occupancy at 1 and updates `main` to the new payload.
- `CD` asserted mid-operation: any payload in `main` or `skid` is discarded with no pop. Outputs clear asynchronously within the same cycle.

## Test plan
- Reset:
  - Assert `CD` mid-cycle with state=FULL.
  - Required: `out_vld`=0, `in_rdy`=0, `occ`=0 immediately.
  - After release: `in_rdy`=0 for one edge, then 1.
  - `out_pd`=0 until the first accept.
- Streaming:
  - Set `out_rdy`=1 constantly. Drive `in_vld`=1 with `in_pd`=0x0,0x1,…,0xF on 16 consecutive cycles.
  - Required: `out_pd` shows 0x0..0xF on 16 consecutive cycles, each one cycle after its accept.
  - `occ`=1 throughout; no bubbles.
- Skid fill:
  - Stream 0xA1,0xA2,0xA3. Drop `out_rdy` on the edge that accepts 0xA2.
  - Required: `occ`=2, `in_rdy`=0, `out_pd`=0xA1 held stable.
  - 0xA3 is not accepted until `out_rdy` returns.
  - Pop order is 0xA1,0xA2,0xA3.
- Drain:
  - From FULL holding (0xB1,0xB2), keep `in_vld`=0 and set `out_rdy`=1 for 3 cycles.
  - Required: `occ` goes 2→1→0; `out_pd` shows 0xB1 then 0xB2; `out_vld`=0 in the third cycle.
- Random back-pressure:
  - 10k cycles with random `in_vld`/`out_rdy` at 50%.
  - Required: a scoreboard shows in-order, lossless, duplicate-free delivery.
  - `out_pd` stable whenever `out_vld & ~out_rdy`.
  - `in_rdy` = (`occ`≠2) after reset release.
- Illegal-but-tolerated upstream:
  - While `in_rdy`=0, toggle `in_vld` and `in_pd` (0xDEAD/0xBEEF) every cycle.
  - Required: no extra entries; `occ` unchanged until a pop.
